alu_exec: RTL and testbench

- Single-issue integer execution unit directly downstream of the reservation station.
- Consumes the instruction the station emits on its front port: front_ok, op, imm, pc, robpos, vj, vk.
- Computes the result, branch decision and jump target, and registers them for one cycle.
- Broadcasts the result on the CDB-style alu_* bus, which feeds back into the station's alu_in_flag/alu_val/alu_robpos inputs and into the ROB.

---
 rtl/alu_exec.sv | 178 +++++++++++++++++
 tb/tb_alu_exec.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Single-issue integer execution unit. Takes one instruction per cycle from the
// reservation station, computes result/branch decision/target combinationally,
// and registers them for one cycle onto the CDB-style output bus.
module alu_exec #(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned ROB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              clear,
  input  logic              in_flag,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_robpos,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  output logic              out_flag,
  output logic [DATA_W-1:0] out_val,
  output logic [ROB_W-1:0]  out_robpos,
  output logic              out_jump,
  output logic [DATA_W-1:0] out_target
);

  localparam logic [OP_W-1:0] OpLui   = OP_W'(0);
  localparam logic [OP_W-1:0] OpAuipc = OP_W'(1);
  localparam logic [OP_W-1:0] OpJal   = OP_W'(2);
  localparam logic [OP_W-1:0] OpJalr  = OP_W'(3);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(4);
  localparam logic [OP_W-1:0] OpBne   = OP_W'(5);
  localparam logic [OP_W-1:0] OpBlt   = OP_W'(6);
  localparam logic [OP_W-1:0] OpBge   = OP_W'(7);
  localparam logic [OP_W-1:0] OpBltu  = OP_W'(8);
  localparam logic [OP_W-1:0] OpBgeu  = OP_W'(9);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(10);
  localparam logic [OP_W-1:0] OpSlti  = OP_W'(11);
  localparam logic [OP_W-1:0] OpSltiu = OP_W'(12);
  localparam logic [OP_W-1:0] OpXori  = OP_W'(13);
  localparam logic [OP_W-1:0] OpOri   = OP_W'(14);
  localparam logic [OP_W-1:0] OpAndi  = OP_W'(15);
  localparam logic [OP_W-1:0] OpSlli  = OP_W'(16);
  localparam logic [OP_W-1:0] OpSrli  = OP_W'(17);
  localparam logic [OP_W-1:0] OpSrai  = OP_W'(18);
  localparam logic [OP_W-1:0] OpAdd   = OP_W'(19);
  localparam logic [OP_W-1:0] OpSub   = OP_W'(20);
  localparam logic [OP_W-1:0] OpSll   = OP_W'(21);
  localparam logic [OP_W-1:0] OpSlt   = OP_W'(22);
  localparam logic [OP_W-1:0] OpSltu  = OP_W'(23);
  localparam logic [OP_W-1:0] OpXor   = OP_W'(24);
  localparam logic [OP_W-1:0] OpSrl   = OP_W'(25);
  localparam logic [OP_W-1:0] OpSra   = OP_W'(26);
  localparam logic [OP_W-1:0] OpOr    = OP_W'(27);
  localparam logic [OP_W-1:0] OpAnd   = OP_W'(28);

  logic              out_flag_q, out_flag_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic [ROB_W-1:0]  out_robpos_q, out_robpos_d;
  logic              out_jump_q, out_jump_d;
  logic [DATA_W-1:0] out_target_q, out_target_d;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] pc_imm;
  logic              lt_s, lt_u, eq;
  logic              is_imm;
  logic [DATA_W-1:0] res_val;
  logic              res_jump;
  logic [DATA_W-1:0] res_target;

  // Operand selection and shared comparators.
  always_comb begin
    imm_ext = DATA_W'($signed(in_imm));
    // I-type ops (ADDI..SRAI) take the immediate as second operand.
    is_imm  = (in_op >= OpAddi) && (in_op <= OpSrai);
    op_b    = is_imm ? imm_ext : in_vk;
    shamt   = op_b[4:0];
    pc4     = in_pc + DATA_W'(4);
    pc_imm  = in_pc + imm_ext;
    lt_s    = $signed(in_vj) < $signed(op_b);
    lt_u    = in_vj < op_b;
    eq      = in_vj == op_b;
  end

  // Opcode decode: result value, branch decision and next PC.
  always_comb begin
    res_val    = '0;
    res_jump   = 1'b0;
    res_target = pc4;
    case (in_op)
      OpLui:   res_val = imm_ext;
      OpAuipc: res_val = pc_imm;
      OpJal: begin
        res_val    = pc4;
        res_jump   = 1'b1;
        res_target = pc_imm;
      end
      OpJalr: begin
        res_val    = pc4;
        res_jump   = 1'b1;
        res_target = (in_vj + imm_ext) & ~DATA_W'(1);
      end
      OpBeq:  res_jump = eq;
      OpBne:  res_jump = !eq;
      OpBlt:  res_jump = lt_s;
      OpBge:  res_jump = !lt_s;
      OpBltu: res_jump = lt_u;
      OpBgeu: res_jump = !lt_u;
      OpAddi, OpAdd:  res_val = in_vj + op_b;
      OpSub:          res_val = in_vj - op_b;
      OpSlti, OpSlt:  res_val = {{(DATA_W-1){1'b0}}, lt_s};
      OpSltiu, OpSltu: res_val = {{(DATA_W-1){1'b0}}, lt_u};
      OpXori, OpXor:  res_val = in_vj ^ op_b;
      OpOri, OpOr:    res_val = in_vj | op_b;
      OpAndi, OpAnd:  res_val = in_vj & op_b;
      OpSlli, OpSll:  res_val = in_vj << shamt;
      OpSrli, OpSrl:  res_val = in_vj >> shamt;
      OpSrai, OpSra:  res_val = $signed(in_vj) >>> shamt;
      default: ;
    endcase
    // Branches only redirect when taken; otherwise fall through to pc+4.
    if ((in_op >= OpBeq) && (in_op <= OpBgeu) && res_jump) begin
      res_target = pc_imm;
    end
  end

  // Next-state for the output registers: clear beats ready; ready=0 holds everything.
  always_comb begin
    out_flag_d   = out_flag_q;
    out_val_d    = out_val_q;
    out_robpos_d = out_robpos_q;
    out_jump_d   = out_jump_q;
    out_target_d = out_target_q;
    if (clear) begin
      out_flag_d = 1'b0;
      out_jump_d = 1'b0;
    end else if (ready) begin
      if (in_flag) begin
        out_flag_d   = 1'b1;
        out_val_d    = res_val;
        out_robpos_d = in_robpos;
        out_jump_d   = res_jump;
        out_target_d = res_target;
      end else begin
        out_flag_d = 1'b0;
        out_jump_d = 1'b0;
      end
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_flag_q   <= 1'b0;
      out_val_q    <= '0;
      out_robpos_q <= '0;
      out_jump_q   <= 1'b0;
      out_target_q <= '0;
    end else begin
      out_flag_q   <= out_flag_d;
      out_val_q    <= out_val_d;
      out_robpos_q <= out_robpos_d;
      out_jump_q   <= out_jump_d;
      out_target_q <= out_target_d;
    end
  end

  assign out_flag   = out_flag_q;
  assign out_val    = out_val_q;
  assign out_robpos = out_robpos_q;
  assign out_jump   = out_jump_q;
  assign out_target = out_target_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed checks with literal expectations plus randomized
// traffic compared every cycle against a behavioural model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset, ready, clear, in_flag;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc, in_vj, in_vk;
  logic [3:0]  in_robpos;
  logic        out_flag, out_jump;
  logic [31:0] out_val, out_target;
  logic [3:0]  out_robpos;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: expected registered outputs; m_known=0 after a flush.
  bit          m_flag, m_jump, m_known;
  logic [31:0] m_val, m_target;
  logic [3:0]  m_rob;
  bit          chk_on = 1'b0;

  alu_exec #(.OP_W(6), .DATA_W(32), .IMM_W(32), .ROB_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .clear      (clear),
    .in_flag    (in_flag),
    .in_op      (in_op),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_robpos  (in_robpos),
    .in_vj      (in_vj),
    .in_vk      (in_vk),
    .out_flag   (out_flag),
    .out_val    (out_val),
    .out_robpos (out_robpos),
    .out_jump   (out_jump),
    .out_target (out_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural result of one instruction, from the ISA rules.
  function automatic void model(input int op, input logic [31:0] imm, pc, a, k,
                                output logic [31:0] v, output bit j,
                                output logic [31:0] t);
    logic [31:0] b;
    int sa, sb, sh;
    b  = (op >= 19) ? k : imm;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    v  = 0;
    j  = 0;
    t  = pc + 4;
    case (op)
      0: v = imm;
      1: v = pc + imm;
      2: begin v = pc + 4; j = 1; t = pc + imm; end
      3: begin v = pc + 4; j = 1; t = (a + imm) & 32'hFFFF_FFFE; end
      4: j = (a == k);
      5: j = (a != k);
      6: j = (sa < int'(k));
      7: j = (sa >= int'(k));
      8: j = (a < k);
      9: j = (a >= k);
      10, 19: v = a + b;
      20: v = a - b;
      11, 22: v = (sa < sb) ? 1 : 0;
      12, 23: v = (a < b) ? 1 : 0;
      13, 24: v = a ^ b;
      14, 27: v = a | b;
      15, 28: v = a & b;
      16, 21: v = a << sh;
      17, 25: v = a >> sh;
      18, 26: v = sa >>> sh;
      default: ;
    endcase
    if (op >= 4 && op <= 9 && j) t = pc + imm;
  endfunction

  // Advance one clock: update model from the inputs seen at this edge.
  task automatic tick();
    logic [31:0] v, t;
    bit j;
    @(posedge clk);
    if (reset) begin
      m_flag = 0; m_val = 0; m_rob = 0; m_jump = 0; m_target = 0; m_known = 1;
    end else if (clear) begin
      m_flag = 0; m_jump = 0; m_known = 0;
    end else if (ready) begin
      if (in_flag) begin
        model(int'(in_op), in_imm, in_pc, in_vj, in_vk, v, j, t);
        m_flag = 1; m_val = v; m_rob = in_robpos; m_jump = j; m_target = t; m_known = 1;
      end else begin
        m_flag = 0; m_jump = 0;
      end
    end
    #1;
  endtask

  task automatic issue(input int op, input logic [31:0] imm, pc, vj, vk,
                       input logic [3:0] rob);
    reset = 0; clear = 0; ready = 1; in_flag = 1;
    in_op = 6'(op); in_imm = imm; in_pc = pc; in_vj = vj; in_vk = vk; in_robpos = rob;
    tick();
  endtask

  task automatic idle();
    reset = 0; clear = 0; ready = 1; in_flag = 0;
    tick();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("flag", 32'(out_flag), 32'(m_flag));
      chk("jump", 32'(out_jump), 32'(m_jump));
      if (m_known) begin
        chk("val", out_val, m_val);
        chk("robpos", 32'(out_robpos), 32'(m_rob));
        chk("target", out_target, m_target);
      end
    end
  end

  initial begin
    reset = 1; ready = 1; clear = 0; in_flag = 0;
    in_op = 0; in_imm = 0; in_pc = 0; in_vj = 0; in_vk = 0; in_robpos = 0;
    tick();
    tick();
    chk_on = 1;
    idle();
    chk("rst_flag", 32'(out_flag), 0);
    chk("rst_val", out_val, 0);
    chk("rst_target", out_target, 0);
    chk("rst_robpos", 32'(out_robpos), 0);

    issue(19, 0, 32'h0, 32'hFFFF_FFFF, 2, 4'd5);
    chk("add_flag", 32'(out_flag), 1);
    chk("add_val", out_val, 1);
    chk("add_rob", 32'(out_robpos), 5);
    chk("add_jump", 32'(out_jump), 0);
    idle();
    chk("idle_flag", 32'(out_flag), 0);

    issue(26, 0, 0, 32'h8000_0000, 32'h24, 4'd1);
    chk("sra_val", out_val, 32'hF800_0000);
    issue(23, 0, 0, 1, 32'hFFFF_FFFF, 4'd2);
    chk("sltu_val", out_val, 1);
    issue(22, 0, 0, 1, 32'hFFFF_FFFF, 4'd3);
    chk("slt_val", out_val, 0);

    issue(6, 32'hFFFF_FFF0, 32'h100, 32'hFFFF_FFFD, 2, 4'd4);
    chk("blt_jump", 32'(out_jump), 1);
    chk("blt_target", out_target, 32'hF0);
    issue(9, 32'hFFFF_FFF0, 32'h100, 32'hFFFF_FFFD, 2, 4'd4);
    chk("bgeu_jump", 32'(out_jump), 1);
    chk("bgeu_target", out_target, 32'hF0);
    issue(4, 32'hFFFF_FFF0, 32'h100, 1, 2, 4'd6);
    chk("beq_jump", 32'(out_jump), 0);
    chk("beq_target", out_target, 32'h104);

    issue(3, 4, 32'h40, 32'h1001, 0, 4'd7);
    chk("jalr_val", out_val, 32'h44);
    chk("jalr_target", out_target, 32'h1004);
    chk("jalr_jump", 32'(out_jump), 1);
    issue(10, 7, 32'h44, 3, 0, 4'd8);
    chk("b2b_flag", 32'(out_flag), 1);
    chk("b2b_rob", 32'(out_robpos), 8);
    chk("addi_val", out_val, 10);

    issue(19, 0, 0, 20, 22, 4'd9);
    ready = 0; in_flag = 1; in_op = 6'd20; in_robpos = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_flag", 32'(out_flag), 1);
      chk("hold_val", out_val, 42);
      chk("hold_rob", 32'(out_robpos), 9);
    end
    ready = 1; clear = 1; in_flag = 1; in_op = 6'd19;
    tick();
    chk("clear_flag", 32'(out_flag), 0);
    issue(2, 32'h20, 32'h200, 0, 0, 4'd1);
    chk("jal_target", out_target, 32'h220);
    ready = 0; clear = 1; in_flag = 0;
    tick();
    chk("clear_nrdy_flag", 32'(out_flag), 0);
    chk("clear_nrdy_jump", 32'(out_jump), 0);
    issue(31, 0, 32'h300, 5, 5, 4'd11);
    chk("unk_flag", 32'(out_flag), 1);
    chk("unk_val", out_val, 0);
    chk("unk_target", out_target, 32'h304);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 19) == 0);
      ready   = ($urandom_range(0, 9) != 0);
      in_flag = ($urandom_range(0, 9) < 7);
      in_op   = 6'($urandom_range(0, 34));
      in_pc   = $urandom & 32'hFFFF_FFFC;
      in_vj   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ $urandom_range(0, 3) : $urandom;
      in_vk   = ($urandom_range(0, 3) == 0) ? in_vj : $urandom;
      in_imm  = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      in_robpos = 4'($urandom);
      tick();
    end
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
